im_loader: RTL and testbench

Instruction-memory loader: the writer side of the instruction RAM's write port (`is_write`/`im_addr`/`im_inst`). It accepts a byte stream from a host link through a valid/ready handshake. It assembles little-endian 32-bit words and writes them to consecutive word addresses starting at `BASE_ADDR`, then verifies an XOR checksum. While loading it holds the core stalled via `core_hold`, so the fetch side (`pc`/`re`) stays idle until the image is complete.

---
 rtl/im_loader_if.sv | 26 ++
 rtl/im_loader.sv | 122 ++++++++++++
 tb/tb_im_loader.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/im_loader_if.sv
// Host-link byte stream plus instruction-RAM write port of the loader.
// The loader takes the slave side; the host/RAM/core environment takes the master side.
interface im_loader_if;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        is_write;
  logic [31:0] im_addr;
  logic [31:0] im_inst;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_written;

  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, is_write, im_addr, im_inst, core_hold, busy, done, err, words_written
  );

  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, is_write, im_addr, im_inst, core_hold, busy, done, err, words_written
  );
endinterface

// File: rtl/im_loader.sv
// Loads a length-prefixed, XOR-checksummed byte frame into instruction RAM,
// one little-endian 32-bit word per write strobe, holding the core while it runs.
module im_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input logic        i_clk,
  input logic        i_rst_n,
  im_loader_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CSUM   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]  r_state;
  logic [15:0] r_len;
  logic [23:0] r_word;
  logic [1:0]  r_byte_idx;
  logic [7:0]  r_csum;
  logic [15:0] r_words;
  logic [31:0] r_addr;
  logic [31:0] r_inst;
  logic        r_err;

  logic        w_rx_ready;
  logic        w_accept;
  logic [15:0] w_len_full;
  logic        w_len_bad;
  logic [31:0] w_word_next;

  assign w_rx_ready  = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                       (r_state == S_DATA)   || (r_state == S_CSUM);
  assign w_accept    = bus.rx_valid && w_rx_ready;
  assign w_len_full  = {bus.rx_data, r_len[7:0]};
  assign w_len_bad   = (w_len_full == 16'd0) || ({16'd0, w_len_full} > 32'(MAX_WORDS));
  // Newest byte enters at the top, so after four bytes the first one sits in [7:0].
  assign w_word_next = {bus.rx_data, r_word};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_len      <= 16'd0;
      r_word     <= 24'd0;
      r_byte_idx <= 2'd0;
      r_csum     <= 8'd0;
      r_words    <= 16'd0;
      r_addr     <= 32'd0;
      r_inst     <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_err      <= 1'b0;
            r_words    <= 16'd0;
            r_byte_idx <= 2'd0;
            r_csum     <= 8'd0;
            r_state    <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_len   <= {8'd0, bus.rx_data};
            r_state <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_len <= w_len_full;
            if (w_len_bad) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_word     <= w_word_next[31:8];
            r_csum     <= r_csum ^ bus.rx_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              // Word index equals words already written; address wraps modulo 2^32.
              r_inst  <= w_word_next;
              r_addr  <= BASE_ADDR + {14'd0, r_words, 2'b00};
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_words <= r_words + 16'd1;
          r_state <= (r_words == r_len - 16'd1) ? S_CSUM : S_DATA;
        end
        S_CSUM: begin
          if (w_accept) begin
            if (bus.rx_data != r_csum) r_err <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rx_ready      = w_rx_ready;
  assign bus.is_write      = (r_state == S_WRITE);
  assign bus.im_addr       = r_addr;
  assign bus.im_inst       = r_inst;
  assign bus.core_hold     = (r_state != S_IDLE);
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.done          = (r_state == S_DONE);
  assign bus.err           = r_err;
  assign bus.words_written = r_words;

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: table vectors, reset corner cases and random frames
// checked against a frame-level reference model.
module tb_im_loader;
  localparam logic [31:0] BASE = 32'h1024_0000;
  localparam int          MAXW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  im_loader_if bus();

  im_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_inst_q[$];
  logic [7:0]  tx_q[$];
  int          done_seen;
  logic        done_err;
  logic [15:0] done_words;

  typedef struct {
    logic [15:0] len;
    logic [63:0] data;
    logic [7:0]  csum;
    logic        exp_err;
    int          exp_writes;
    logic [31:0] exp_inst0;
    logic [31:0] exp_inst1;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write/done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.is_write === 1'b1) begin
      wr_addr_q.push_back(bus.im_addr);
      wr_inst_q.push_back(bus.im_inst);
      chk("rx_ready_during_write", 32'(bus.rx_ready), 0);
      $display("write addr=%h inst=%h", bus.im_addr, bus.im_inst);
    end
    if (bus.done === 1'b1) begin
      done_seen++;
      done_err   = bus.err;
      done_words = bus.words_written;
    end
  end

  function automatic int pick_gap(input bit rg);
    return rg ? int'($urandom_range(0, 3)) : 0;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    int budget;
    ok = 1'b0;
    bus.rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    budget = 200;
    while (!ok && budget > 0) begin
      if (bus.rx_ready === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
      budget--;
    end
    bus.rx_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL byte_timeout: byte %h not accepted within 200 cycles", b);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rx_ready"},  32'(bus.rx_ready), 0);
    chk({tag, "_is_write"},  32'(bus.is_write), 0);
    chk({tag, "_im_addr"},   bus.im_addr, 0);
    chk({tag, "_im_inst"},   bus.im_inst, 0);
    chk({tag, "_core_hold"}, 32'(bus.core_hold), 0);
    chk({tag, "_busy"},      32'(bus.busy), 0);
    chk({tag, "_done"},      32'(bus.done), 0);
    chk({tag, "_err"},       32'(bus.err), 0);
    chk({tag, "_words"},     32'(bus.words_written), 0);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Runs the frame in tx_q (len lo, len hi, data..., csum) and checks it
  // against expectations derived from the frame contents alone.
  task automatic run_frame(input bit rg);
    logic [15:0] n;
    bit          len_bad;
    logic [7:0]  x;
    bit          exp_err;
    bit          ok;
    int          nw;
    logic [31:0] ea[$];
    logic [31:0] ei[$];
    n       = {tx_q[1], tx_q[0]};
    len_bad = (n == 16'd0) || (32'(n) > 32'(MAXW));
    nw      = len_bad ? 0 : int'(n);
    x       = 8'd0;
    for (int w = 0; w < nw; w++) begin
      ea.push_back(BASE + 32'(4 * w));
      ei.push_back({tx_q[5 + 4*w], tx_q[4 + 4*w], tx_q[3 + 4*w], tx_q[2 + 4*w]});
    end
    for (int i = 0; i < 4 * nw; i++) x ^= tx_q[2 + i];
    exp_err = len_bad ? 1'b1 : (tx_q[2 + 4*nw] != x);

    wr_addr_q.delete();
    wr_inst_q.delete();
    done_seen = 0;
    pulse_start();
    chk("start_rx_ready",  32'(bus.rx_ready), 1);
    chk("start_core_hold", 32'(bus.core_hold), 1);
    chk("start_err_clear", 32'(bus.err), 0);
    send_byte(tx_q[0], pick_gap(rg), ok);
    send_byte(tx_q[1], pick_gap(rg), ok);
    if (len_bad) begin
      chk("lenerr_done",  32'(bus.done), 1);
      chk("lenerr_err",   32'(bus.err), 1);
      chk("lenerr_words", 32'(bus.words_written), 0);
      bus.rx_data  = 8'h5a;
      bus.rx_valid = 1'b1;
      @(posedge clk); #1;
      chk("lenerr_idle", 32'(bus.busy), 0);
      repeat (2) begin @(posedge clk); #1; end
      chk("lenerr_no_consume", 32'(bus.rx_ready), 0);
      bus.rx_valid = 1'b0;
    end else begin
      for (int i = 0; i < 4 * nw; i++) begin
        send_byte(tx_q[2 + i], pick_gap(rg), ok);
        if (i % 4 == 3) begin
          chk("word_is_write",  32'(bus.is_write), 1);
          chk("word_rx_ready0", 32'(bus.rx_ready), 0);
          chk("word_addr",      bus.im_addr, ea[i / 4]);
          chk("word_inst",      bus.im_inst, ei[i / 4]);
          if (!rg) begin
            @(posedge clk); #1;
            chk("word_rx_ready1", 32'(bus.rx_ready), 1);
          end
        end
      end
      send_byte(tx_q[2 + 4*nw], pick_gap(rg), ok);
      chk("csum_done",  32'(bus.done), 1);
      chk("csum_err",   32'(bus.err), 32'(exp_err));
      chk("csum_words", 32'(bus.words_written), 32'(nw));
      @(posedge clk); #1;
      chk("end_core_hold", 32'(bus.core_hold), 0);
      chk("end_done_low",  32'(bus.done), 0);
      chk("end_hold_inst", bus.im_inst, ei[nw - 1]);
    end
    chk("done_pulses", 32'(done_seen), 1);
    chk("done_err",    32'(done_err), 32'(exp_err));
    chk("n_writes",    32'(wr_inst_q.size()), 32'(nw));
    for (int w = 0; w < nw && w < wr_inst_q.size(); w++) begin
      chk("model_addr", wr_addr_q[w], ea[w]);
      chk("model_inst", wr_inst_q[w], ei[w]);
    end
    $display("frame len=%0d err=%0b writes=%0d", n, done_err, wr_inst_q.size());
  endtask

  task automatic load_vec(input vec_t v);
    tx_q.delete();
    tx_q.push_back(v.len[7:0]);
    tx_q.push_back(v.len[15:8]);
    for (int j = 0; j < 4 * v.exp_writes; j++) tx_q.push_back(v.data[8*j +: 8]);
    if (v.exp_writes > 0) tx_q.push_back(v.csum);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int kind;
    int n;
    logic [7:0] x;

    vecs[0] = '{16'd2,      64'h0001_2567_1246_78f8, 8'h97, 1'b0, 2, 32'h1246_78f8, 32'h0001_2567};
    vecs[1] = '{16'd2,      64'h0001_2567_1246_78f8, 8'h00, 1'b1, 2, 32'h1246_78f8, 32'h0001_2567};
    vecs[2] = '{16'd0,      64'h0,                   8'h00, 1'b1, 0, 32'h0,         32'h0};
    vecs[3] = '{16'd9,      64'h0,                   8'h00, 1'b1, 0, 32'h0,         32'h0};
    vecs[4] = '{16'd1,      64'h0000_0000_ddcc_bbaa, 8'h00, 1'b0, 1, 32'hddcc_bbaa, 32'h0};
    vecs[5] = '{16'h0100,   64'h0,                   8'h00, 1'b1, 0, 32'h0,         32'h0};

    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst_n        = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) begin
      load_vec(vecs[k]);
      run_frame(1'b0);
      chk("vec_err",    32'(done_err), 32'(vecs[k].exp_err));
      chk("vec_writes", 32'(wr_inst_q.size()), 32'(vecs[k].exp_writes));
      if (vecs[k].exp_writes >= 1 && wr_inst_q.size() >= 1) chk("vec_inst0", wr_inst_q[0], vecs[k].exp_inst0);
      if (vecs[k].exp_writes >= 2 && wr_inst_q.size() >= 2) chk("vec_inst1", wr_inst_q[1], vecs[k].exp_inst1);
      $display("vector %0d err=%0b writes=%0d", k, done_err, wr_inst_q.size());
    end

    // Reset after the 6th data byte: first word written, second dropped.
    load_vec(vecs[0]);
    wr_addr_q.delete();
    wr_inst_q.delete();
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(tx_q[i], 0, ok);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset("rst_mid");
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_mid_writes", 32'(wr_inst_q.size()), 1);
    $display("reset after 6th data byte: writes=%0d", wr_inst_q.size());

    // Reset landing in the WRITE cycle.
    load_vec(vecs[4]);
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(tx_q[i], 0, ok);
    chk("rst_write_strobe", 32'(bus.is_write), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset("rst_write");
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset during write checked");

    // Start together with reset: reset wins.
    rst_n     = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("start_in_reset_busy", 32'(bus.busy), 0);
    chk("start_in_reset_rdy",  32'(bus.rx_ready), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", 32'(bus.busy), 0);

    // Fresh session after resets, with random gaps.
    load_vec(vecs[0]);
    run_frame(1'b1);

    for (int r = 0; r < 20; r++) begin
      tx_q.delete();
      kind = int'($urandom_range(0, 7));
      n = (kind == 0) ? 0 : (kind == 1) ? MAXW + 1 : int'($urandom_range(1, MAXW));
      tx_q.push_back(8'(n));
      tx_q.push_back(8'(n >> 8));
      if (kind > 1) begin
        x = 8'd0;
        for (int j = 0; j < 4 * n; j++) begin
          tx_q.push_back(8'($urandom_range(0, 255)));
          x ^= tx_q[tx_q.size() - 1];
        end
        if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
        tx_q.push_back(x);
      end
      run_frame(1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
